// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register of an in-order integer pipeline. Reads the source
//   operands (with a write-through bypass from the writeback port), detects
//   load-use hazards, and either captures the ID instruction into EX or loads
//   a bubble. It also keeps two saturating performance counters.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   id_*                        decoded instruction currently in ID
//   ru_rs1, ru_rs2              combinational register-file read data
//   wb_we, wb_rd, wb_data       writeback port (same as register-file write)
//   flush                       taken branch/jump: kill the ID instruction
//   stall                       load-use hazard: PC and IF/ID must hold
//   ex_*                        registered EX-stage fields
//   stall_cnt, flush_cnt        saturating performance counters
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_is_load,
    input  logic [31:0]       ru_rs1,
    input  logic [31:0]       ru_rs2,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_rs1_val,
    output logic [31:0]       ex_rs2_val,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_is_load,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // x0 reads as zero; a same-cycle writeback to the source wins over the
    // register file so the value written this cycle is not missed.
    function automatic logic [31:0] src_value(input logic [4:0]  idx,
                                              input logic [31:0] ru,
                                              input logic        we,
                                              input logic [4:0]  rd,
                                              input logic [31:0] data);
        if (idx == 5'd0)
            return 32'h0;
        else if (we && (rd == idx))
            return data;
        else
            return ru;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic              ex_valid_q,   ex_valid_d;
    logic [31:0]       ex_pc_q,      ex_pc_d;
    logic [31:0]       ex_rs1_val_q, ex_rs1_val_d;
    logic [31:0]       ex_rs2_val_q, ex_rs2_val_d;
    logic [31:0]       ex_imm_q,     ex_imm_d;
    logic [4:0]        ex_rs1_q,     ex_rs1_d;
    logic [4:0]        ex_rs2_q,     ex_rs2_d;
    logic [4:0]        ex_rd_q,      ex_rd_d;
    logic [CTRL_W-1:0] ex_ctrl_q,    ex_ctrl_d;
    logic              ex_is_load_q, ex_is_load_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q,  flush_cnt_d;

    // Load-use hazard: the load in EX has not produced its data yet. The
    // bubble it causes clears ex_is_load, so the stall lasts one cycle.
    assign stall = id_valid && ex_valid_q && ex_is_load_q && (ex_rd_q != 5'd0) &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd_q)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd_q)));

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_pc_d      = ex_pc_q;
        ex_rs1_val_d = ex_rs1_val_q;
        ex_rs2_val_d = ex_rs2_val_q;
        ex_imm_d     = ex_imm_q;
        ex_rs1_d     = ex_rs1_q;
        ex_rs2_d     = ex_rs2_q;
        ex_rd_d      = ex_rd_q;
        ex_ctrl_d    = ex_ctrl_q;
        ex_is_load_d = ex_is_load_q;

        if (flush || stall) begin
            // Bubble: only the control-relevant fields are cleared; the data
            // fields keep their old values since consumers ignore them.
            ex_valid_d   = 1'b0;
            ex_ctrl_d    = '0;
            ex_is_load_d = 1'b0;
            ex_rd_d      = 5'd0;
            ex_rs1_d     = 5'd0;
            ex_rs2_d     = 5'd0;
        end else begin
            ex_valid_d   = id_valid;
            ex_pc_d      = id_pc;
            ex_imm_d     = id_imm;
            ex_rs1_d     = id_rs1;
            ex_rs2_d     = id_rs2;
            ex_rs1_val_d = src_value(id_rs1, ru_rs1, wb_we, wb_rd, wb_data);
            ex_rs2_val_d = src_value(id_rs2, ru_rs2, wb_we, wb_rd, wb_data);
            // An empty ID slot must not look like a writer or a load in EX.
            ex_ctrl_d    = id_valid ? id_ctrl    : '0;
            ex_is_load_d = id_valid ? id_is_load : 1'b0;
            ex_rd_d      = id_valid ? id_rd      : 5'd0;
        end

        stall_cnt_d = (stall && !flush)    ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = (flush && id_valid)  ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= 32'h0;
            ex_rs1_val_q <= 32'h0;
            ex_rs2_val_q <= 32'h0;
            ex_imm_q     <= 32'h0;
            ex_rs1_q     <= 5'd0;
            ex_rs2_q     <= 5'd0;
            ex_rd_q      <= 5'd0;
            ex_ctrl_q    <= '0;
            ex_is_load_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_pc_q      <= ex_pc_d;
            ex_rs1_val_q <= ex_rs1_val_d;
            ex_rs2_val_q <= ex_rs2_val_d;
            ex_imm_q     <= ex_imm_d;
            ex_rs1_q     <= ex_rs1_d;
            ex_rs2_q     <= ex_rs2_d;
            ex_rd_q      <= ex_rd_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_is_load_q <= ex_is_load_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign ex_valid   = ex_valid_q;
    assign ex_pc      = ex_pc_q;
    assign ex_rs1_val = ex_rs1_val_q;
    assign ex_rs2_val = ex_rs2_val_q;
    assign ex_imm     = ex_imm_q;
    assign ex_rs1     = ex_rs1_q;
    assign ex_rs2     = ex_rs2_q;
    assign ex_rd      = ex_rd_q;
    assign ex_ctrl    = ex_ctrl_q;
    assign ex_is_load = ex_is_load_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule
